// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address + R/W, one data byte with ACK handling,
// then STOP or repeated START. Open-drain SDA, phase-driven SCL, no stretching.
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] slave_addr,
  input  logic       rw,
  input  logic [7:0] data_in,
  input  logic       repeated_start_cond,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       scl_out,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    STOP,
    RSTART
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       phase;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_shift;
  logic [7:0]       rx_shift;
  logic [7:0]       data_lat;
  logic             rw_lat;
  logic             ack_bit;
  logic             tick;
  logic             sample;
  logic             bit_end;

  assign tick    = (state != IDLE) && (div_cnt == DIV_LAST);
  assign sample  = tick && (phase == 2'd2);
  assign bit_end = tick && (phase == 2'd3);

  // Bus pins decode straight from state/phase so every quarter lines up with the tick.
  always_comb begin
    state_nxt = state;
    scl_out   = 1'b1;
    sda_out   = 1'b1;
    case (state)
      IDLE: begin
        if (enable) state_nxt = START;
      end
      START: begin
        sda_out = ~phase[1];
        if (bit_end) state_nxt = ADDR;
      end
      ADDR: begin
        scl_out = phase[1];
        sda_out = tx_shift[7];
        if (bit_end && bit_cnt == 3'd7) state_nxt = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_out = phase[1];
        if (bit_end) begin
          if (ack_bit)     state_nxt = STOP;
          else if (rw_lat) state_nxt = READ;
          else             state_nxt = WRITE;
        end
      end
      WRITE: begin
        scl_out = phase[1];
        sda_out = tx_shift[7];
        if (bit_end && bit_cnt == 3'd7) state_nxt = WRITE_ACK;
      end
      READ: begin
        scl_out = phase[1];
        if (bit_end && bit_cnt == 3'd7) state_nxt = READ_ACK;
      end
      WRITE_ACK, READ_ACK: begin
        scl_out = phase[1];
        if (bit_end) state_nxt = repeated_start_cond ? RSTART : STOP;
      end
      STOP: begin
        scl_out = (phase != 2'd0);
        sda_out = phase[1];
        if (bit_end) state_nxt = IDLE;
      end
      RSTART: begin
        scl_out = (phase != 2'd0);
        sda_out = ~phase[1];
        if (bit_end) state_nxt = ADDR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      phase    <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      data_lat <= '0;
      rw_lat   <= 1'b0;
      ack_bit  <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;

      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;

      if (state == IDLE) phase <= '0;
      else if (tick)     phase <= phase + 2'd1;

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (enable) begin
            tx_shift <= {slave_addr, rw};
            rw_lat   <= rw;
            data_lat <= data_in;
            ack_err  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ADDR, WRITE: begin
          if (bit_end) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            bit_cnt  <= bit_cnt + 3'd1;
          end
        end
        ADDR_ACK: begin
          if (sample) begin
            ack_bit <= sda_in;
            if (sda_in) ack_err <= 1'b1;
          end
          if (bit_end) tx_shift <= data_lat;
        end
        WRITE_ACK: begin
          if (sample && sda_in) ack_err <= 1'b1;
        end
        READ: begin
          if (sample)  rx_shift <= {rx_shift[6:0], sda_in};
          if (bit_end) bit_cnt  <= bit_cnt + 3'd1;
        end
        READ_ACK: begin
          if (bit_end) data_out <= rx_shift;
        end
        STOP: begin
          if (bit_end) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        RSTART: begin
          if (bit_end) begin
            done     <= 1'b1;
            tx_shift <= {slave_addr, rw};
            rw_lat   <= rw;
            data_lat <= data_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: behavioural slave/bus monitor on the
// wired-AND SDA line, immediate-assertion checks at each step.
module tb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [6:0] slave_addr;
  logic       rw;
  logic [7:0] data_in;
  logic       repeated_start_cond;
  logic       sda_out;
  logic       scl_out;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       sda_line;
  logic       slave_sda = 1'b1;

  logic       ack_addr;
  logic       ack_data;
  logic [7:0] rd_byte;

  int errors = 0;
  int checks = 0;

  assign sda_line = sda_out & slave_sda;

  i2c_master_ctrl #(.CLK_DIV(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .slave_addr          (slave_addr),
    .rw                  (rw),
    .data_in             (data_in),
    .repeated_start_cond (repeated_start_cond),
    .sda_in              (sda_line),
    .sda_out             (sda_out),
    .scl_out             (scl_out),
    .data_out            (data_out),
    .busy                (busy),
    .done                (done),
    .ack_err             (ack_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and slave model, evaluated mid-cycle.
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       prev_busy = 1'b0;
  logic [7:0] prev_dout = 8'h00;
  logic [7:0] sh = 8'h00;
  logic       is_read = 1'b0;
  logic       in_frame = 1'b0;
  logic [7:0] byte_log [0:63];
  logic       ack_log  [0:63];
  int k = 0;
  int byte_idx = 0;
  int nbytes = 0;
  int nacks = 0;
  int start_cnt = 0;
  int sr_cnt = 0;
  int stop_cnt = 0;
  int rd_viol = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_rise_cyc = 0;
  int busy_fall_cnt = 0;
  int dout_chg_cyc = 0;
  logic [7:0] done_data = 8'h00;

  always @(negedge clk) begin
    prev_scl  <= scl_out;
    prev_sda  <= sda_line;
    prev_busy <= busy;
    prev_dout <= data_out;
    if (busy && !prev_busy) busy_rise_cyc <= cyc;
    if (!busy && prev_busy) busy_fall_cnt <= busy_fall_cnt + 1;
    if (done) begin
      done_cnt  <= done_cnt + 1;
      done_cyc  <= cyc;
      done_data <= data_out;
    end
    if (data_out != prev_dout) dout_chg_cyc <= cyc;

    if (prev_scl && scl_out && prev_sda && !sda_line) begin
      k         <= 0;
      byte_idx  <= 0;
      start_cnt <= start_cnt + 1;
      if (in_frame) sr_cnt <= sr_cnt + 1;
      in_frame  <= 1'b1;
    end else if (prev_scl && scl_out && !prev_sda && sda_line) begin
      stop_cnt <= stop_cnt + 1;
      in_frame <= 1'b0;
    end else if (!prev_scl && scl_out) begin
      if (k < 8) begin
        sh <= {sh[6:0], sda_line};
        if (byte_idx == 1 && is_read && !sda_out) rd_viol <= rd_viol + 1;
        if (k == 7) begin
          byte_log[nbytes] <= {sh[6:0], sda_line};
          nbytes <= nbytes + 1;
          if (byte_idx == 0) is_read <= sda_line;
        end
        k <= k + 1;
      end else begin
        ack_log[nacks] <= sda_line;
        nacks    <= nacks + 1;
        k        <= 0;
        byte_idx <= byte_idx + 1;
      end
    end else if (prev_scl && !scl_out) begin
      if (k == 8) begin
        if (byte_idx == 0)  slave_sda <= ~ack_addr;
        else if (!is_read)  slave_sda <= ~ack_data;
        else                slave_sda <= 1'b1;
      end else if (byte_idx == 1 && is_read) begin
        slave_sda <= rd_byte[7-k];
      end else begin
        slave_sda <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int target, input int bound);
    int n;
    n = 0;
    while (done_cnt < target && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_within_bound", 32'(done_cnt >= target), 1);
  endtask

  task automatic request(input logic [6:0] a, input logic r, input logic [7:0] d);
    slave_addr = a;
    rw         = r;
    data_in    = d;
    enable     = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
  endtask

  int b0, a0, s0, st0, d0, sr0, bf0, rv0;

  initial begin
    rst_n = 1'b0; enable = 1'b0; slave_addr = '0; rw = 1'b0; data_in = '0;
    repeated_start_cond = 1'b0; ack_addr = 1'b1; ack_data = 1'b1; rd_byte = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl_out, 1);
    chk("rst_sda", sda_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_data_out", data_out, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write 0x55 to 0x2A
    b0 = nbytes; a0 = nacks; s0 = stop_cnt; st0 = start_cnt; d0 = done_cnt;
    request(7'h2A, 1'b0, 8'h55);
    chk("wr_busy_rise", busy, 1);
    wait_done(d0 + 1, 1000);
    chk("wr_addr_byte", byte_log[b0], 8'h54);
    chk("wr_addr_ack", ack_log[a0], 0);
    chk("wr_data_byte", byte_log[b0+1], 8'h55);
    chk("wr_data_ack", ack_log[a0+1], 0);
    chk("wr_nbytes", nbytes - b0, 2);
    chk("wr_duration", done_cyc - busy_rise_cyc, 320);
    chk("wr_ack_err", ack_err, 0);
    chk("wr_starts", start_cnt - st0, 1);
    chk("wr_stops", stop_cnt - s0, 1);
    chk("wr_busy_fall", busy, 0);

    // Read 0xA5 from 0x2A
    b0 = nbytes; a0 = nacks; d0 = done_cnt; rv0 = rd_viol;
    rd_byte = 8'hA5;
    request(7'h2A, 1'b1, 8'h00);
    wait_done(d0 + 1, 1000);
    chk("rd_addr_byte", byte_log[b0], 8'h55);
    chk("rd_addr_ack", ack_log[a0], 0);
    chk("rd_bus_byte", byte_log[b0+1], 8'hA5);
    chk("rd_master_nack", ack_log[a0+1], 1);
    chk("rd_data_at_done", done_data, 8'hA5);
    chk("rd_data_hold", data_out, 8'hA5);
    chk("rd_sda_released", rd_viol - rv0, 0);
    chk("rd_dout_lead", done_cyc - dout_chg_cyc, 16);
    chk("rd_duration", done_cyc - busy_rise_cyc, 320);

    // Address NACK
    b0 = nbytes; a0 = nacks; s0 = stop_cnt; d0 = done_cnt;
    ack_addr = 1'b0;
    request(7'h2A, 1'b0, 8'h33);
    wait_done(d0 + 1, 1000);
    chk("nack_ack_err", ack_err, 1);
    chk("nack_nbytes", nbytes - b0, 1);
    chk("nack_addr_byte", byte_log[b0], 8'h54);
    chk("nack_ack_bit", ack_log[a0], 1);
    chk("nack_duration", done_cyc - busy_rise_cyc, 176);
    chk("nack_stop", stop_cnt - s0, 1);
    ack_addr = 1'b1;

    // ack_err clears on accept; enable mid-transaction ignored
    b0 = nbytes; d0 = done_cnt;
    request(7'h2A, 1'b0, 8'h3C);
    chk("clr_ack_err", ack_err, 0);
    repeat (49) @(posedge clk);
    #1;
    request(7'h11, 1'b0, 8'hEE);
    wait_done(d0 + 1, 1000);
    repeat (400) @(posedge clk);
    #1;
    chk("busy_one_done", done_cnt - d0, 1);
    chk("busy_idle_after", busy, 0);
    chk("busy_nbytes", nbytes - b0, 2);
    chk("busy_addr_byte", byte_log[b0], 8'h54);
    chk("busy_data_byte", byte_log[b0+1], 8'h3C);

    // Repeated start: write 0x11, then read from 0x2B
    b0 = nbytes; a0 = nacks; s0 = stop_cnt; d0 = done_cnt; sr0 = sr_cnt; bf0 = busy_fall_cnt;
    rd_byte = 8'hC3;
    repeated_start_cond = 1'b1;
    request(7'h2A, 1'b0, 8'h11);
    repeat (200) @(posedge clk);
    #1;
    slave_addr = 7'h2B;
    rw         = 1'b1;
    wait_done(d0 + 1, 600);
    repeated_start_cond = 1'b0;
    chk("sr_busy_held", busy, 1);
    wait_done(d0 + 2, 600);
    chk("sr_done_pulses", done_cnt - d0, 2);
    chk("sr_busy_one_fall", busy_fall_cnt - bf0, 1);
    chk("sr_edge", sr_cnt - sr0, 1);
    chk("sr_one_stop", stop_cnt - s0, 1);
    chk("sr_byte0", byte_log[b0], 8'h54);
    chk("sr_byte1", byte_log[b0+1], 8'h11);
    chk("sr_byte2", byte_log[b0+2], 8'h57);
    chk("sr_byte3", byte_log[b0+3], 8'hC3);
    chk("sr_ack2", ack_log[a0+2], 0);
    chk("sr_ack3", ack_log[a0+3], 1);
    chk("sr_read_data", done_data, 8'hC3);

    // Reset during WRITE
    d0 = done_cnt;
    request(7'h2A, 1'b0, 8'h55);
    repeat (179) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rst_scl", scl_out, 1);
    chk("mid_rst_sda", sda_out, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt - d0, 0);
    b0 = nbytes; d0 = done_cnt;
    request(7'h2A, 1'b0, 8'h0F);
    chk("post_rst_busy", busy, 1);
    wait_done(d0 + 1, 1000);
    chk("post_rst_addr", byte_log[b0], 8'h54);
    chk("post_rst_data", byte_log[b0+1], 8'h0F);
    chk("post_rst_ack_err", ack_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
